serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
- Serial stimulus transmitter, the driving end of the single-bit sample stream consumed by the team's windowed sequence detectors.
- Accepts a parallel pattern word through a valid/ready load handshake.
- Shifts the word out LSB-first, one bit per clock, optionally repeated.
- Emits a golden "more than one 1 in the last 3 samples" flag alongside each bit, so benches can check a detector without a separate model.

Parameters:
- WIDTH, 10, maximum pattern length in bits.
- LEN_W, 4, width of the length field (must satisfy 2**LEN_W > WIDTH).
- REP_W, 4, width of the repeat-count field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- load_valid  input  1  a pattern is offered.
- load_ready  output  1  the transmitter can accept a pattern.
- load_data  input  WIDTH  pattern; bit 0 is sent first.
- load_len  input  LEN_W  number of bits to send; 0 or values above WIDTH mean WIDTH.
- load_rep  input  REP_W  extra repetitions; the frame is sent load_rep+1 times.
- abort  input  1  stops the current transfer.
- x  output  1  serial sample; 0 whenever x_valid=0.
- x_valid  output  1  x carries a sample this cycle.
- exp_y  output  1  golden detector flag for the current sample.
- busy  output  1  the state is not IDLE.
- done  output  1  one-cycle pulse after the final bit of the final repetition.

Behaviour:
- Reset values: state=IDLE, x=0, x_valid=0, exp_y=0, busy=0, done=0, load_ready=0 during the rst cycle, window history=2'b00. rst overrides every other input.
- States are IDLE, SHIFT and DONE. All outputs are registered.
- IDLE:
  - load_ready=1.
  - Acceptance occurs when load_valid&&load_ready: latch load_data, the clamped length L and load_rep; clear the window history; go to SHIFT.
  - load_valid with no acceptance has no effect.
- SHIFT:
  - Entered the cycle after acceptance. That cycle presents bit 0 with x_valid=1, so the first-bit latency from acceptance is 1 cycle.
  - Each cycle presents data[idx] and then increments idx.
  - When idx==L-1 and the repeat counter is above 0: set idx=0, decrement the counter, and stay in SHIFT. There is no gap cycle between repetitions.
  - When idx==L-1 and the counter is 0: go to DONE.
- DONE:
  - x_valid=0, done=1 for exactly one cycle, then IDLE.
  - load_ready=0 in DONE. Back-to-back frames therefore have one dead cycle in DONE and one in IDLE.
- abort:
  - In SHIFT: the next cycle is IDLE with x_valid=0. done is not asserted and the window history is cleared.
  - In IDLE or DONE: ignored.
- exp_y:
  - Equals x_valid && (x + h[0] + h[1] >= 2), where h holds the previous two valid samples (h[0] is the most recent).
  - h shifts only on valid cycles and persists across repetitions.
  - exp_y is registered together with x, so it is aligned to the same cycle.
- Counters:
  - idx is LEN_W bits; the repeat counter is REP_W bits.
  - No wrap: the terminal compare happens before increment or decrement.
- busy=1 in SHIFT and DONE.

Decomposition:
- Shared package sensor_pkg holds:
  - the state typedef (IDLE/SHIFT/DONE);
  - the default WIDTH, LEN_W and REP_W constants;
  - the window threshold constant WIN_ONES_MIN=2.
- One sub-module, win3_flag: a 2-bit history shift register plus the population-count compare.
  - Ports: clk, rst, clr, in_valid, in_bit, flag.
  - It is reusable by the detector-side checkers.

Test Plan:
- Basic frame: load_data=10'b1001101010, len=10, rep=0.
  - x=0,1,0,1,0,1,1,0,0,1 on 10 consecutive cycles.
  - exp_y=0,0,0,1,0,1,1,1,0,0.
  - done pulses on the 11th cycle after the first bit.
  - load_ready returns to 1 one cycle later.
- Repeat: data=3'b011, len=3, rep=2.
  - x=1,1,0,1,1,0,1,1,0 with x_valid high continuously for 9 cycles.
  - exp_y=0,1,1,1,1,1,1,1,1.
  - done is asserted once.
- Length clamp: len=0 and, separately, len=15 with WIDTH=10. Both transmit exactly 10 bits.
- Abort: assert abort on the 4th bit of a 10-bit frame.
  - The next cycle has x_valid=0, busy=0, and no done pulse.
  - A new load is then accepted and its exp_y history starts empty (the first two bits give exp_y=0).
- Reset mid-frame: rst on the 5th bit.
  - The following cycle has all outputs 0 and load_ready=0.
  - load_ready=1 the cycle after rst deasserts.
- Handshake: hold load_valid=1 while busy.
  - No second acceptance until IDLE.
  - The second frame's first bit appears exactly 1 cycle after acceptance.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and constants for the serial stimulus transmitter and detector-side checkers.
package sensor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } tx_state_t;

    localparam int DEF_WIDTH    = 10;
    localparam int DEF_LEN_W    = 4;
    localparam int DEF_REP_W    = 4;
    localparam int WIN_ONES_MIN = 2;

    function automatic logic [1:0] ones3(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

endpackage

// File: rtl/win3_flag.sv
// Three-sample window flag: registered "at least WIN_ONES_MIN ones among the
// incoming bit and the previous two valid bits".
module win3_flag
    import sensor_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_valid,
    input  logic in_bit,
    output logic flag
);

    logic [1:0] r_hist;
    logic       r_flag;
    logic [1:0] w_hist;
    logic [1:0] w_ones;

    // clr takes effect for the sample arriving in the same cycle
    assign w_hist = clr ? 2'b00 : r_hist;
    assign w_ones = ones3(in_bit, w_hist[0], w_hist[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b00;
            r_flag <= 1'b0;
        end else begin
            r_flag <= in_valid && (w_ones >= 2'(WIN_ONES_MIN));
            if (in_valid) begin
                r_hist <= {w_hist[0], in_bit};
            end else begin
                r_hist <= w_hist;
            end
        end
    end

    assign flag = r_flag;

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: loads a word by valid/ready, shifts it out LSB-first
// with optional repeats, and emits the golden 3-sample window flag per bit.
module serial_pattern_tx
    import sensor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [REP_W-1:0] load_rep,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             exp_y,
    output logic             busy,
    output logic             done
);

    tx_state_t        r_state;
    logic [LEN_W-1:0] r_idx;
    logic [LEN_W-1:0] r_len;
    logic [REP_W-1:0] r_rep;
    logic [WIDTH-1:0] r_data;
    logic             r_x;
    logic             r_x_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_load_ready;

    tx_state_t        w_state_nx;
    logic [LEN_W-1:0] w_idx_nx;
    logic [LEN_W-1:0] w_len_nx;
    logic [REP_W-1:0] w_rep_nx;
    logic [WIDTH-1:0] w_data_nx;
    logic             w_clr;
    logic             w_x_nx;
    logic             w_x_valid_nx;
    logic [LEN_W-1:0] w_len_clamped;

    assign w_len_clamped = ((load_len == '0) || (load_len > LEN_W'(WIDTH))) ?
                           LEN_W'(WIDTH) : load_len;

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_len_nx   = r_len;
        w_rep_nx   = r_rep;
        w_data_nx  = r_data;
        w_clr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_valid && r_load_ready) begin
                    w_state_nx = ST_SHIFT;
                    w_idx_nx   = '0;
                    w_len_nx   = w_len_clamped;
                    w_rep_nx   = load_rep;
                    w_data_nx  = load_data;
                    w_clr      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_nx = ST_IDLE;
                    w_clr      = 1'b1;
                end else if (r_idx == r_len - LEN_W'(1)) begin
                    if (r_rep != '0) begin
                        w_idx_nx = '0;
                        w_rep_nx = r_rep - REP_W'(1);
                    end else begin
                        w_state_nx = ST_DONE;
                    end
                end else begin
                    w_idx_nx = r_idx + LEN_W'(1);
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
        // outputs are computed for the upcoming cycle so they can be registered
        w_x_valid_nx = (w_state_nx == ST_SHIFT);
        w_x_nx       = w_x_valid_nx && w_data_nx[w_idx_nx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_len        <= '0;
            r_rep        <= '0;
            r_data       <= '0;
            r_x          <= 1'b0;
            r_x_valid    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_idx        <= w_idx_nx;
            r_len        <= w_len_nx;
            r_rep        <= w_rep_nx;
            r_data       <= w_data_nx;
            r_x          <= w_x_nx;
            r_x_valid    <= w_x_valid_nx;
            r_busy       <= (w_state_nx != ST_IDLE);
            r_done       <= (w_state_nx == ST_DONE);
            r_load_ready <= (w_state_nx == ST_IDLE);
        end
    end

    win3_flag u_win3_flag (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .in_valid (w_x_valid_nx),
        .in_bit   (w_x_nx),
        .flag     (exp_y)
    );

    assign x          = r_x;
    assign x_valid    = r_x_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign load_ready = r_load_ready;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx with hand-computed sample and flag sequences.
module tb_serial_pattern_tx;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [9:0] load_data;
    logic [3:0] load_len;
    logic [3:0] load_rep;
    logic       abort;
    logic       x;
    logic       x_valid;
    logic       exp_y;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    serial_pattern_tx dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_rep   (load_rep),
        .abort      (abort),
        .x          (x),
        .x_valid    (x_valid),
        .exp_y      (exp_y),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Waits (bounded) for load_ready, offers one pattern, returns in the first-bit cycle.
    task automatic start(input string tag, input logic [9:0] d, input logic [3:0] l,
                         input logic [3:0] r);
        int t = 0;
        while (!load_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_ready"}, load_ready, 1'b1);
        load_valid = 1'b1;
        load_data  = d;
        load_len   = l;
        load_rep   = r;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic run_bits(input string tag, input logic [15:0] xs, input logic [15:0] ys,
                            input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_xv%0d", tag, i), x_valid, 1'b1);
            chk($sformatf("%s_x%0d", tag, i), x, xs[i]);
            chk($sformatf("%s_y%0d", tag, i), exp_y, ys[i]);
            chk($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
            chk($sformatf("%s_done%0d", tag, i), done, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_dn_xv"}, x_valid, 1'b0);
        chk({tag, "_dn_done"}, done, 1'b1);
        chk({tag, "_dn_busy"}, busy, 1'b1);
        chk({tag, "_dn_rdy"}, load_ready, 1'b0);
        @(negedge clk);
        chk({tag, "_idle_done"}, done, 1'b0);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_idle_rdy"}, load_ready, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        load_rep   = '0;
        abort      = 1'b0;

        @(negedge clk);
        chk("rst_x", x, 1'b0);
        chk("rst_xv", x_valid, 1'b0);
        chk("rst_y", exp_y, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rdy", load_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", load_ready, 1'b1);

        // basic frame
        start("basic", 10'b1001101010, 4'd10, 4'd0);
        run_bits("basic", 16'(10'b1001101010), 16'(10'b0011101000), 10);
        check_done("basic");

        // three repetitions of a 3-bit pattern, no gaps
        start("rep", 10'b0000000011, 4'd3, 4'd2);
        run_bits("rep", 16'(9'b011011011), 16'(9'b111111110), 9);
        check_done("rep");

        // length clamps
        start("len0", 10'b1000000001, 4'd0, 4'd0);
        run_bits("len0", 16'(10'b1000000001), 16'(10'b0000000000), 10);
        check_done("len0");
        start("len15", 10'b1100000000, 4'd15, 4'd0);
        run_bits("len15", 16'(10'b1100000000), 16'(10'b1000000000), 10);
        check_done("len15");
        start("len1", 10'b0000000001, 4'd1, 4'd0);
        run_bits("len1", 16'h0001, 16'h0000, 1);
        check_done("len1");

        // abort on the 4th bit, then history must restart empty
        start("abt", 10'h3FF, 4'd10, 4'd0);
        run_bits("abt", 16'h0007, 16'h0006, 3);
        chk("abt_xv3", x_valid, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abt_xv", x_valid, 1'b0);
        chk("abt_busy", busy, 1'b0);
        chk("abt_done", done, 1'b0);
        chk("abt_rdy", load_ready, 1'b1);
        start("abn", 10'b0000000001, 4'd2, 4'd0);
        run_bits("abn", 16'h0001, 16'h0000, 2);
        check_done("abn");

        // synchronous reset on the 5th bit
        start("mrst", 10'h155, 4'd10, 4'd0);
        run_bits("mrst", 16'h0005, 16'h0004, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_x", x, 1'b0);
        chk("mrst_xv", x_valid, 1'b0);
        chk("mrst_y", exp_y, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_rdy", load_ready, 1'b0);
        @(negedge clk);
        chk("mrst_rdy2", load_ready, 1'b1);
        chk("mrst_busy2", busy, 1'b0);

        // load_valid held high across a whole frame
        load_valid = 1'b1;
        load_data  = 10'b0000000011;
        load_len   = 4'd2;
        load_rep   = 4'd0;
        @(negedge clk);
        load_data  = 10'b0000000101;
        load_len   = 4'd3;
        chk("hs_a_rdy0", load_ready, 1'b0);
        run_bits("hs_a", 16'h0003, 16'h0002, 2);
        check_done("hs_a");
        @(negedge clk);
        load_valid = 1'b0;
        run_bits("hs_b", 16'h0005, 16'h0004, 3);
        check_done("hs_b");
        @(negedge clk);
        chk("hs_end_busy", busy, 1'b0);
        chk("hs_end_xv", x_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
